// File: rtl/fifo_serializer_pkg.sv
// fifo_ser_pkg: shared state type and default widths for the FIFO word serializer
package fifo_ser_pkg;
    typedef enum logic [0:0] {S_IDLE, S_SEND} ser_state_t;
    localparam int BITS_DEF  = 32;
    localparam int OUT_W_DEF = 8;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if: FIFO read port plus the narrow valid/ready beat channel
interface fifo_serializer_if
    import fifo_ser_pkg::*;
#(
    parameter int bits  = BITS_DEF,
    parameter int out_w = OUT_W_DEF
) ();
    logic [bits-1:0]  fifo_dout;
    logic             fifo_pndng;
    logic             fifo_pop;
    logic [out_w-1:0] ser_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    modport master (
        input  fifo_dout, fifo_pndng, ser_ready,
        output fifo_pop, ser_data, ser_valid, ser_last
    );
    modport slave (
        output fifo_dout, fifo_pndng, ser_ready,
        input  fifo_pop, ser_data, ser_valid, ser_last
    );
endinterface

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops FIFO words and emits them as LSB-first narrow beats with a last flag
module fifo_serializer
    import fifo_ser_pkg::*;
#(
    parameter int bits  = BITS_DEF,
    parameter int out_w = OUT_W_DEF,
    parameter int cnt_w = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    fifo_serializer_if.master io,
    output logic             busy,
    output logic [cnt_w-1:0] word_count
);
    localparam int beats = bits / out_w;
    localparam int bc_w  = beats > 1 ? $clog2(beats) : 1;

    if (bits % out_w != 0 || out_w > bits) begin : g_bad_width
        $error("fifo_serializer: bits must be a multiple of out_w and out_w <= bits");
    end

    ser_state_t      state;
    logic [bits-1:0] shreg;
    logic [bc_w-1:0] beat_cnt;
    logic            last, fire, load;

    assign last = beat_cnt == bc_w'(beats - 1);
    assign fire = io.ser_valid && io.ser_ready;
    // a new word is taken from idle, or on the final handshake so words stream without a bubble
    assign load = en && io.fifo_pndng && (state == S_IDLE || (fire && last));

    assign io.fifo_pop  = !rst && load;
    assign io.ser_valid = state == S_SEND;
    assign io.ser_data  = shreg[out_w-1:0];
    assign io.ser_last  = io.ser_valid && last;
    assign busy         = state == S_SEND;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            beat_cnt   <= '0;
            word_count <= '0;
        end else begin
            if (fire && last) word_count <= word_count + 1'b1;
            if (load) begin
                shreg    <= io.fifo_dout;
                beat_cnt <= '0;
                state    <= S_SEND;
            end else if (fire) begin
                shreg    <= shreg >> out_w;
                beat_cnt <= last ? '0 : beat_cnt + 1'b1;
                state    <= last ? S_IDLE : S_SEND;
            end
        end
    end
endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: queue-modelled FIFO feeding the serializer, beats checked against a scoreboard
module tb_fifo_serializer;
    import fifo_ser_pkg::*;
    localparam int BW = 32, OW = 8, CW = 3, NB = BW / OW;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, busy;
    logic [CW-1:0] word_count;
    logic [BW-1:0] fq[$];
    logic [OW:0]   exp_q[$];
    logic [CW-1:0] wc_m = '0;
    int n_vec = 0, n_err = 0;

    fifo_serializer_if #(.bits(BW), .out_w(OW)) io ();

    fifo_serializer #(.bits(BW), .out_w(OW), .cnt_w(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .io(io.master), .busy(busy), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic refresh();
        io.fifo_pndng = fq.size() != 0;
        if (fq.size() != 0) io.fifo_dout = fq[0];
        else io.fifo_dout = '0;
    endtask

    // one clock: drive at negedge, check before the edge, update FIFO and scoreboard after it
    task automatic cyc(input logic r, input logic e, input logic rdy);
        logic exp_pop, got_pop;
        logic [OW:0] h;
        logic [BW-1:0] w;
        rst = r;
        en = e;
        io.ser_ready = rdy;
        refresh();
        #1;
        exp_pop = !r && e && fq.size() != 0 && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
        got_pop = io.fifo_pop;
        chk("pop", got_pop, exp_pop);
        if (!r) begin
            chk("valid", io.ser_valid, exp_q.size() != 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("count", word_count, wc_m);
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                chk("data", io.ser_data, h[OW-1:0]);
                chk("last", io.ser_last, h[OW]);
            end
        end
        w = fq.size() != 0 ? fq[0] : '0;
        @(posedge clk);
        #1;
        if (got_pop && fq.size() != 0) void'(fq.pop_front());
        if (r) begin
            exp_q.delete();
            wc_m = '0;
        end else begin
            if (exp_q.size() != 0 && rdy) begin
                h = exp_q.pop_front();
                if (h[OW]) wc_m++;
            end
            if (exp_pop)
                for (int i = 0; i < NB; i++) exp_q.push_back({i == NB - 1, w[i*OW +: OW]});
        end
        @(negedge clk);
    endtask

    initial begin
        io.ser_ready = 1'b0;
        refresh();
        @(negedge clk);
        // reset with a word pending: no pop may escape
        fq.push_back(32'hA1B2C3D4);
        repeat (2) cyc(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_data", io.ser_data, 0);
        chk("rst_last", io.ser_last, 0);
        chk("rst_valid", io.ser_valid, 0);
        chk("rst_count", word_count, 0);
        // single word
        repeat (6) cyc(1'b0, 1'b1, 1'b1);
        chk("t2_count", word_count, 1);
        // backpressure on the second beat
        fq.push_back(32'hA1B2C3D4);
        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b1);
        chk("t3_count", word_count, 2);
        // back-to-back words
        fq.push_back(32'h11223344);
        fq.push_back(32'h55667788);
        repeat (9) cyc(1'b0, 1'b1, 1'b1);
        chk("t4_count", word_count, 4);
        // enable dropped mid-word
        fq.push_back(32'hDEADBEEF);
        fq.push_back(32'h01020304);
        fq.push_back(32'hF0E0D0C0);
        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b0, 1'b1);
        chk("t5_hold", fq.size(), 2);
        repeat (9) cyc(1'b0, 1'b1, 1'b1);
        chk("t5_count", word_count, 7);
        // reset mid-word discards the in-flight word
        fq.push_back(32'hA1B2C3D4);
        fq.push_back(32'hCAFEF00D);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("t6_fifo", fq.size(), 1);
        repeat (6) cyc(1'b0, 1'b1, 1'b1);
        chk("t6_count", word_count, 1);
        // random stream, wraps the narrow word counter
        for (int i = 0; i < 12; i++) fq.push_back($urandom);
        for (int i = 0; i < 80; i++) cyc(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 60 && (fq.size() != 0 || exp_q.size() != 0); i++) cyc(1'b0, 1'b1, 1'b1);
        chk("drain_fifo", fq.size(), 0);
        chk("drain_beats", exp_q.size(), 0);
        chk("final_count", word_count, 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
Downstream consumer of the word FIFO. Pops full-width words from the FIFO's read side and emits each one as a sequence of narrow beats on a valid/ready output channel, LSB beat first, with a last-beat flag. It sits between the FIFO read port (Dout/pop/pndng) and a narrow link or driver interface, and keeps a running count of words it has consumed.

Parameters:
bits, 32, FIFO word width; must equal the upstream FIFO's bits.
out_w, 8, output beat width; bits % out_w == 0 and out_w <= bits (elaboration error otherwise).
cnt_w, 16, width of word_count.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
en  input  1  1 = may start new words; 0 = finish current word, then stop popping
fifo_dout  input  bits  FIFO head word; valid whenever fifo_pndng=1 (show-ahead)
fifo_pndng  input  1  FIFO non-empty
fifo_pop  output  1  one-cycle pop strobe; FIFO removes head at this posedge
ser_data  output  out_w  current beat
ser_valid  output  1  beat valid
ser_ready  input  1  sink accepts beat when ser_valid && ser_ready at posedge
ser_last  output  1  current beat is the final beat of its word
busy  output  1  word in flight (state SEND)
word_count  output  cnt_w  words fully transmitted since reset, wraps modulo 2^cnt_w

Behaviour:
- BEATS = bits/out_w. beat_cnt width = max(1,$clog2(BEATS)).
- Reset (rst=1 at posedge): state IDLE, shreg=0, beat_cnt=0, word_count=0. While rst=1, fifo_pop=0 combinationally. Outputs after reset: ser_valid=0, ser_last=0, busy=0, ser_data=0, word_count=0.
- fifo_pop is combinational: pop = !rst && load, where load = en && fifo_pndng && (state==IDLE || (state==SEND && ser_valid && ser_ready && beat_cnt==BEATS-1)).
- IDLE: ser_valid=0. On load: shreg<=fifo_dout, beat_cnt<=0, state<=SEND. Pop and capture happen on the same edge. Latency: first beat is valid in the cycle after the pop.
- SEND: ser_valid=1, ser_data=shreg[out_w-1:0], ser_last=(beat_cnt==BEATS-1), busy=1.
  - No handshake: shreg, beat_cnt and ser_data are held stable.
  - Handshake on a non-last beat: shreg shifts right by out_w (zero-fill), beat_cnt++.
  - Handshake on the last beat: word_count++. If load, capture the next word and stay in SEND with beat_cnt=0, so there is no bubble between words. Otherwise go to IDLE.
- BEATS==1: every beat has ser_last=1, and a sustained stream reaches one word per cycle.
- en=0 never aborts a word in flight. It only suppresses load. en toggling while in SEND has no effect until the last-beat handshake.
- fifo_pndng falling while in SEND has no effect; the word is already captured.
- Reset mid-word: the in-flight word is discarded (not re-pushed), the partial count is not incremented, and no pop occurs during reset.
- word_count wraps from 2^cnt_w-1 to 0.
- fifo_dout is sampled only on load edges; it is don't-care otherwise.

Decomposition:
- Package fifo_ser_pkg holds typedef enum logic [0:0] {S_IDLE, S_SEND} ser_state_t and the default constants for bits, out_w and cnt_w.
- No sub-module: the shift register, beat counter and FSM live in one module.
- The FIFO is instantiated only in the bench, which wires fifo_dout, fifo_pndng and fifo_pop to the FIFO's Dout, pndng and pop.

Test Plan:
1. Reset: rst=1 for 2 cycles with fifo_pndng=1 -> fifo_pop=0 throughout; after release, all outputs are 0 and word_count=0.
2. Single word: FIFO holds 0xA1B2C3D4, ser_ready=1, en=1.
   - fifo_pop pulses in cycle 0.
   - ser_data is D4, C3, B2, A1 in cycles 1-4, with ser_last only with A1.
   - Cycle 5: ser_valid=0, word_count=1.
3. Backpressure: same word, ser_ready=0 for 3 cycles while 0xC3 is presented -> ser_data holds 0xC3 and ser_valid=1 for all 3 cycles; the sequence completes in order and word_count=1.
4. Back-to-back: FIFO holds 0x11223344 and 0x55667788, ready=1.
   - 8 consecutive valid beats 44,33,22,11,88,77,66,55 with no bubble.
   - fifo_pop pulses exactly in cycles 0 and 4.
   - word_count=2.
5. Enable gating: drop en during beat 2 of a word while fifo_pndng=1 -> the word completes, then no pop and ser_valid=0 for 5 cycles. Raising en pops the next word in that same cycle.
6. Reset mid-word: assert rst after 2 beats of 0xA1B2C3D4.
   - Next cycle: ser_valid=0, busy=0, word_count unchanged (0).
   - After release, the next FIFO word is popped and serialized from its first beat.
